kanagawa_loop_arbiter: RTL and testbench

KANAGAWA_LOOP_ARBITER -- requirements
Module: kanagawa_loop_arbiter

---
 rtl/kanagawa_loop_arb_pkg.sv | 12 +
 rtl/kanagawa_rr_pick.sv | 27 ++
 rtl/kanagawa_loop_arbiter.sv | 154 +++++++++++++++
 tb/tb_kanagawa_loop_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kanagawa_loop_arb_pkg.sv
// Shared types for the kanagawa loop arbiter.
// FSM state encoding and statistics counter width.
package kanagawa_loop_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int STATS_WIDTH = 32;

endpackage

// File: rtl/kanagawa_rr_pick.sv
// Round-robin search: first set bit of mask at or above ptr,
// wrapping around to bit 0.
module kanagawa_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] index,
  output logic          found
);

  always_comb begin
    int j;
    index = '0;
    found = 1'b0;
    // walk downward so the nearest requester is written last
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (mask[j]) begin
        index = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kanagawa_loop_arbiter.sv
// Burst round-robin arbiter feeding one output register.
// Define KANAGAWA_LOOP_ARB_STATS_EN to add grant_count_out.
module kanagawa_loop_arbiter
  import kanagawa_loop_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TOTAL_WIDTH = 128,
  parameter  int BURST       = 4,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             empty_in,
  input  logic [NUM_REQ*TOTAL_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]             rden_out,
  output logic [TOTAL_WIDTH-1:0]         data_out,
  output logic [IW-1:0]                  src_out,
  output logic                           empty_out,
  input  logic                           rden_in,
  output logic                           underflow_out
`ifdef KANAGAWA_LOOP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_WIDTH-1:0] grant_count_out
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(BURST);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         g_q, g_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [TOTAL_WIDTH-1:0] data_q;
  logic [IW-1:0]         src_q;
  logic                  empty_q;
  logic                  uf_q;

  logic                  free;
  logic                  pop;
  logic [IW-1:0]         pop_idx;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic [TOTAL_WIDTH-1:0] rec [NUM_REQ];

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] x
  );
    nxt = (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      rec[i] = data_in[i*TOTAL_WIDTH +: TOTAL_WIDTH];
  end

  kanagawa_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .mask  (~empty_in),
    .ptr   (ptr_q),
    .index (pick_idx),
    .found (pick_found)
  );

  assign free = empty_q | rden_in;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    pop_idx = g_q;
    unique case (state_q)
      IDLE: begin
        if (free && pick_found) begin
          pop     = 1'b1;
          pop_idx = pick_idx;
          g_d     = pick_idx;
          if (BURST == 1) begin
            ptr_d = nxt(pick_idx);
          end else begin
            state_d = LOCKED;
            cnt_d   = 8'd1;
          end
        end
      end
      LOCKED: begin
        // release costs one bubble even if the stage is free
        if (empty_in[g_q] || cnt_q == CNT_MAX) begin
          state_d = IDLE;
          ptr_d   = nxt(g_q);
        end else if (free) begin
          pop   = 1'b1;
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
    endcase
  end

  // pop is combinational; force it quiet while reset is held
  assign rden_out = (rst && pop) ?
                    (NUM_REQ'(1) << pop_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      empty_q <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      uf_q    <= rden_in & empty_q;
      if (pop) begin
        data_q  <= rec[pop_idx];
        src_q   <= pop_idx;
        empty_q <= 1'b0;
      end else if (rden_in) begin
        empty_q <= 1'b1;
      end
    end
  end

  assign data_out      = data_q;
  assign src_out       = src_q;
  assign empty_out     = empty_q;
  assign underflow_out = uf_q;

`ifdef KANAGAWA_LOOP_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] gcnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        gcnt_q[i] <= '0;
    end else if (pop) begin
      gcnt_q[pop_idx] <= gcnt_q[pop_idx] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      grant_count_out[i*STATS_WIDTH +: STATS_WIDTH] = gcnt_q[i];
  end
`endif

endmodule

// File: tb/tb_kanagawa_loop_arbiter.sv
// Bench for kanagawa_loop_arbiter: two instances (BURST 4 and 2)
// share stimulus and are checked against a queue-based model.
module tb_kanagawa_loop_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int B0 = 4;
  localparam int B1 = 2;

  logic         clk;
  logic         rst;
  logic         rden_in;
  logic [N-1:0] empty_in [2];
  logic [N*W-1:0] data_in [2];
  logic [N-1:0] rout [2];
  logic [W-1:0] dout [2];
  logic [1:0]   sout [2];
  logic         eout [2];
  logic         ufo  [2];
`ifdef KANAGAWA_LOOP_ARB_STATS_EN
  logic [N*32-1:0] gco [2];
`endif

  kanagawa_loop_arbiter #(
    .NUM_REQ(N), .TOTAL_WIDTH(W), .BURST(B0)
  ) u0 (
    .clk(clk), .rst(rst),
    .empty_in(empty_in[0]), .data_in(data_in[0]),
    .rden_out(rout[0]), .data_out(dout[0]),
    .src_out(sout[0]), .empty_out(eout[0]),
    .rden_in(rden_in), .underflow_out(ufo[0])
`ifdef KANAGAWA_LOOP_ARB_STATS_EN
    , .grant_count_out(gco[0])
`endif
  );

  kanagawa_loop_arbiter #(
    .NUM_REQ(N), .TOTAL_WIDTH(W), .BURST(B1)
  ) u1 (
    .clk(clk), .rst(rst),
    .empty_in(empty_in[1]), .data_in(data_in[1]),
    .rden_out(rout[1]), .data_out(dout[1]),
    .src_out(sout[1]), .empty_out(eout[1]),
    .rden_in(rden_in), .underflow_out(ufo[1])
`ifdef KANAGAWA_LOOP_ARB_STATS_EN
    , .grant_count_out(gco[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // bench-side requester FIFOs, index lane*4 + requester
  logic [W-1:0] q [8][$];

  bit           m_locked [2];
  int           m_g [2], m_cnt [2], m_ptr [2];
  logic [W-1:0] m_data [2];
  int           m_src [2];
  bit           m_empty [2], m_uf [2];
  int           dcnt [2];
  int           tr0 [$];
  int           tr1 [$];
  int           seq = 0;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_locked[l] = 0; m_g[l] = 0; m_cnt[l] = 0; m_ptr[l] = 0;
      m_data[l] = '0; m_src[l] = 0; m_empty[l] = 1; m_uf[l] = 0;
      dcnt[l] = 0;
    end
    tr0.delete(); tr1.delete();
  endtask

  task automatic load(int r, int n);
    logic [W-1:0] rec;
    for (int i = 0; i < n; i++) begin
      rec = {4'(r), 4'hA, 8'(seq), 16'($urandom)};
      seq++;
      q[r].push_back(rec);
      q[4+r].push_back(rec);
    end
  endtask

  task automatic check_regs(int l);
    chk($sformatf("data_out u%0d", l), dout[l], m_data[l]);
    chk($sformatf("src_out u%0d", l), sout[l], m_src[l]);
    chk($sformatf("empty_out u%0d", l), eout[l], m_empty[l]);
    chk($sformatf("underflow_out u%0d", l), ufo[l], m_uf[l]);
  endtask

  task automatic drive(bit rd);
    rden_in = rd;
    for (int l = 0; l < 2; l++)
      for (int r = 0; r < N; r++) begin
        empty_in[l][r] = (q[l*4+r].size() == 0);
        data_in[l][r*W +: W] =
          (q[l*4+r].size() != 0) ? q[l*4+r][0] : '0;
      end
  endtask

  task automatic step(int l);
    int b, p, base, s;
    bit fr;
    b = (l == 0) ? B0 : B1;
    base = l * 4;
    p = -1;
    fr = m_empty[l] || rden_in;
    if (!m_locked[l]) begin
      if (fr)
        for (int k = 0; k < N; k++) begin
          s = (m_ptr[l] + k) % N;
          if (p < 0 && q[base+s].size() != 0) p = s;
        end
      if (p >= 0) begin
        if (b == 1) m_ptr[l] = (p + 1) % N;
        else begin
          m_locked[l] = 1; m_g[l] = p; m_cnt[l] = 1;
        end
      end
    end else if (q[base+m_g[l]].size() == 0 || m_cnt[l] == b) begin
      m_locked[l] = 0;
      m_ptr[l] = (m_g[l] + 1) % N;
    end else if (fr) begin
      p = m_g[l];
      m_cnt[l]++;
    end
    chk($sformatf("rden_out u%0d", l), rout[l],
        (p >= 0) ? (1 << p) : 0);
    if (rden_in && !m_empty[l]) dcnt[l]++;
    m_uf[l] = rden_in && m_empty[l];
    if (p >= 0) begin
      m_data[l] = q[base+p].pop_front();
      m_src[l] = p;
      m_empty[l] = 0;
    end else if (rden_in) begin
      m_empty[l] = 1;
    end
    if (l == 0) tr0.push_back(p);
    else tr1.push_back(p);
  endtask

  task automatic cycle(bit rd);
    for (int l = 0; l < 2; l++) check_regs(l);
    drive(rd);
    #1;
    for (int l = 0; l < 2; l++) step(l);
    @(negedge clk);
  endtask

  task automatic cycles(bit rd, int n);
    for (int i = 0; i < n; i++) cycle(rd);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("rst empty_out u%0d", l), eout[l], 1);
      chk($sformatf("rst data_out u%0d", l), dout[l], 0);
      chk($sformatf("rst src_out u%0d", l), sout[l], 0);
      chk($sformatf("rst rden_out u%0d", l), rout[l], 0);
      chk($sformatf("rst underflow u%0d", l), ufo[l], 0);
`ifdef KANAGAWA_LOOP_ARB_STATS_EN
      chk($sformatf("rst grant_count u%0d", l), gco[l], 0);
`endif
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic int tr_at(int l, int i);
    if (l == 0) return (i < tr0.size()) ? tr0[i] : -99;
    return (i < tr1.size()) ? tr1[i] : -99;
  endfunction

  task automatic chk_tr(string nm, int l, int e[]);
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s u%0d[%0d]", nm, l, i), tr_at(l, i), e[i]);
  endtask

  int e30a [] = '{0,0,0,0,-1,0,0,0,0,-1,0,0};
  int e30b [] = '{0,0,-1,0,0,-1,0,0,-1,0,0,-1};
  int e32a [] = '{2,-1,3,3,3,-1};
  int e32b [] = '{2,-1,3,3,-1,3};
  int e31a [];
  int e31b [];
  logic [W-1:0] first_rec;
  int nz;

  initial begin
    rst = 1'b0;
    rden_in = 1'b0;
    for (int l = 0; l < 2; l++) begin
      empty_in[l] = '1;
      data_in[l] = '0;
    end
    @(negedge clk);
    do_reset();

    // single requester, 10 records, downstream always ready
    load(0, 10);
    cycles(1, 20);
    chk_tr("burst0", 0, e30a);
    chk_tr("burst0", 1, e30b);
    chk("delivered u0", dcnt[0], 10);
    chk("delivered u1", dcnt[1], 10);

    // all four requesters loaded: fair rotation
    do_reset();
    for (int r = 0; r < N; r++) load(r, 8);
    cycles(1, 52);
    e31a = new[40];
    e31b = new[40];
    for (int c = 0; c < 40; c++) begin
      e31a[c] = (c % 5 == 4) ? -1 : (c / 5) % 4;
      e31b[c] = (c % 3 == 2) ? -1 : (c / 3) % 4;
    end
    chk_tr("rr", 0, e31a);
    chk_tr("rr", 1, e31b);
    chk("rr delivered u0", dcnt[0], 32);
    chk("rr delivered u1", dcnt[1], 32);

    // requester 2 runs dry while locked
    do_reset();
    load(2, 1);
    load(3, 3);
    cycles(1, 10);
    chk_tr("dry", 0, e32a);
    chk_tr("dry", 1, e32b);

    // downstream stalls 20 cycles
    do_reset();
    load(1, 6);
    first_rec = q[1][0];
    cycle(1);
    cycles(0, 20);
    nz = 0;
    for (int i = 1; i <= 20; i++)
      if (tr_at(0, i) != -1 || tr_at(1, i) != -1) nz++;
    chk("stall pops", nz, 0);
    chk("stall data u0", dout[0], first_rec);
    chk("stall data u1", dout[1], first_rec);
    cycles(1, 14);
    chk("stall delivered u0", dcnt[0], 6);
    chk("stall delivered u1", dcnt[1], 6);

    // underflow pulse on an empty stage
    cycles(0, 2);
    chk("uf idle", ufo[0], 0);
    cycle(1);
    chk("uf pulse u0", ufo[0], 1);
    chk("uf pulse u1", ufo[1], 1);
    cycle(0);
    chk("uf clear u0", ufo[0], 0);
    chk("uf empty u0", eout[0], 1);

    // reset in the middle of a burst
    do_reset();
    load(0, 8);
    load(1, 8);
    cycles(1, 2);
    do_reset();
    cycles(1, 3);
    chk("post-rst first u0", tr_at(0, 0), 0);
    chk("post-rst first u1", tr_at(1, 0), 0);
    cycles(1, 30);
    chk("post-rst delivered u0", dcnt[0], 14);
    chk("post-rst delivered u1", dcnt[1], 14);
    cycle(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
